// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the MIPS HI/LO multiply/divide sequencer.
//   muldiv_op_e    : operation select, same encoding as funct[1:0]
//   muldiv_state_e : sequencer states
//   DIV0_LO_BIT    : fill bit for LO on divide by zero (LO = all ones)
package mips_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } muldiv_state_e;

    localparam logic DIV0_LO_BIT = 1'b1;

    // Signed variants are the even funct codes (MULT, DIV).
    function automatic logic op_is_signed(input muldiv_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv_seq_engine.sv
// muldiv_engine: unsigned magnitude datapath for the HI/LO sequencer.
// Radix-2 shift-add multiply and radix-2 restoring divide sharing one
// 2*WIDTH accumulator: the upper half is the running product / partial
// remainder, the lower half the multiplier / dividend-turned-quotient.
// With MULDIV_FAST_MUL_EN defined a multiply step produces the whole product.
// Ports:
//   clk, reset, clock_enable : clock, sync active-high reset, global hold
//   load   : capture operands (a_mag, b_mag) and mode (is_div)
//   step   : perform one iteration
//   is_div : 1 = divide, 0 = multiply (sampled with load)
//   a_mag, b_mag : unsigned operand magnitudes
//   acc    : accumulator ({product} or {remainder, quotient})
module muldiv_engine
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clock_enable,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   acc
);

    localparam int unsigned AW = 2 * WIDTH;
    localparam int unsigned RW = WIDTH + 1;

    logic [WIDTH-1:0] operand;   // multiplicand or divisor
    logic             div_mode;

    logic [AW-1:0]    mul_next;
    logic [AW-1:0]    div_next;
    logic [RW-1:0]    rem_shift;
    logic [RW-1:0]    rem_diff;
    logic             q_bit;

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle product of multiplicand and multiplier (low half).
    assign mul_next = AW'(operand) * AW'(acc[WIDTH-1:0]);
`else
    logic [RW-1:0]    mul_sum;

    // Add multiplicand when the current multiplier bit is set, then shift right.
    assign mul_sum  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, operand} : RW'(0));
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
`endif

    // Restoring step: shift next dividend bit in, keep the difference if non-negative.
    assign rem_shift = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, operand};
    assign q_bit     = ~rem_diff[WIDTH];
    assign div_next  = {(q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], q_bit};

    // Accumulator and operand registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            operand  <= '0;
            div_mode <= 1'b0;
        end else if (clock_enable) begin
            if (load) begin
                acc      <= is_div ? {WIDTH'(0), a_mag} : {WIDTH'(0), b_mag};
                operand  <= is_div ? b_mag : a_mag;
                div_mode <= is_div;
            end else if (step) begin
                acc      <= div_mode ? div_next : mul_next;
            end
        end
    end

endmodule

// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply step).
// Ports:
//   clk, reset, clock_enable : clock, sync active-high reset, global hold
//   start, op, op_a, op_b    : operation request (sampled only in IDLE)
//   mthi, mtlo, mt_data      : HI/LO moves; abort an operation in flight
//   mf_req                   : decode stage is executing MFHI/MFLO
//   hi, lo                   : architectural HI/LO
//   busy                     : operation in flight
//   done                     : one-cycle pulse after HI/LO are updated
//   stall                    : combinational mf_req && busy
module mips_muldiv_seq
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clock_enable,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [WIDTH-1:0]  mt_data,
    input  logic              mf_req,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo,
    output logic              busy,
    output logic              done,
    output logic              stall
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW    = 2 * WIDTH;

    muldiv_state_e    state, state_next;
    logic [CNT_W-1:0] counter;
    logic             res_neg;      // product/quotient needs negation
    logic             rem_neg;      // remainder takes dividend sign
    logic             div_zero;
    logic             is_div_q;

    logic             load, step, write_res, mt_any;
    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [AW-1:0]    acc, prod;
    logic [WIDTH-1:0] quot, rem, res_hi, res_lo;

    assign mt_any    = mthi | mtlo;
    assign op_signed = op_is_signed(muldiv_op_e'(op));
    assign a_neg     = op_signed & op_a[WIDTH-1];
    assign b_neg     = op_signed & op_b[WIDTH-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;

    assign busy  = (state != ST_IDLE);
    assign stall = mf_req && busy;

    muldiv_engine #(.WIDTH(WIDTH)) u_engine (
        .clk          (clk),
        .reset        (reset),
        .clock_enable (clock_enable),
        .load         (load),
        .step         (step),
        .is_div       (op[1]),
        .a_mag        (a_mag),
        .b_mag        (b_mag),
        .acc          (acc)
    );

    // Sign fix-up of the magnitude result.
    assign prod   = res_neg ? -acc : acc;
    assign quot   = acc[WIDTH-1:0];
    assign rem    = acc[AW-1:WIDTH];
    assign res_hi = is_div_q ? (rem_neg ? -rem : rem) : prod[AW-1:WIDTH];
    assign res_lo = is_div_q ? (div_zero ? {WIDTH{DIV0_LO_BIT}} : (res_neg ? -quot : quot))
                             : prod[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (clock_enable) begin
            state <= state_next;
        end
    end

    // Next state and control; any MT move pre-empts start or aborts the operation.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        write_res  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !mt_any) begin
                    load       = 1'b1;
                    state_next = op[1] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                if (mt_any) begin
                    state_next = ST_IDLE;
                end else begin
                    step = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                    state_next = ST_FIX;
`else
                    if (counter == '0) state_next = ST_FIX;
`endif
                end
            end
            ST_DIV: begin
                if (mt_any) begin
                    state_next = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (counter == '0) state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                state_next = ST_IDLE;
                if (!mt_any) write_res = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Counter, sign flags, HI/LO and done.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter  <= '0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            is_div_q <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else if (clock_enable) begin
            done <= write_res;
            if (load) begin
                counter  <= CNT_W'(WIDTH - 1);
                res_neg  <= a_neg ^ b_neg;
                rem_neg  <= a_neg;
                div_zero <= (op_b == '0);
                is_div_q <= op[1];
            end else if (step && counter != '0) begin
                counter  <= counter - CNT_W'(1);
            end
            if (write_res) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (mthi) hi <= mt_data;
            if (mtlo) lo <= mt_data;
        end
    end

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Self-checking bench for mips_muldiv_seq: directed cases plus random
// operations, results checked through an expected-result queue drained on done.
module tb_mips_muldiv_seq;

    localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 2;
    localparam int ABORT_AT = 1;
`else
    localparam int MUL_LAT  = 33;
    localparam int ABORT_AT = 10;
`endif
    localparam int DIV_LAT = 33;

    logic         clk = 1'b0;
    logic         reset, clock_enable, start, mthi, mtlo, mf_req;
    logic [1:0]   op;
    logic [W-1:0] op_a, op_b, mt_data, hi, lo;
    logic         busy, done, stall;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [63:0]  exp_q[$];
    logic [31:0]  model_hi, model_lo;

    always #5 clk = ~clk;

    mips_muldiv_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .clock_enable (clock_enable),
        .start        (start),
        .op           (op),
        .op_a         (op_a),
        .op_b         (op_b),
        .mthi         (mthi),
        .mtlo         (mtlo),
        .mt_data      (mt_data),
        .mf_req       (mf_req),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .done         (done),
        .stall        (stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference results straight from MIPS HI/LO semantics.
    task automatic ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] eh, output logic [31:0] el);
        int          ia, ib;
        longint      p;
        logic [63:0] up;
        ia = $signed(a);
        ib = $signed(b);
        case (o)
            2'b00: begin
                p  = longint'(ia) * longint'(ib);
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    eh = 32'd0; el = 32'h8000_0000;
                end else begin
                    el = 32'(ia / ib);
                    eh = 32'(ia % ib);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFF_FFFF;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 100));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 hi=0x%0h lo=0x%0h, expected no done", hi, lo);
            end else begin
                e = exp_q.pop_front();
                check("result_hi", 64'(hi), 64'(e[63:32]));
                check("result_lo", 64'(lo), 64'(e[31:0]));
            end
        end
    end

    // One operation from IDLE to done, with optional stall/extra-start/clock-hold probes.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit use_mf, input int ce_at, input bit extra_start);
        logic [31:0] eh, el;
        int          cyc, exp_len;
        ref_model(o, a, b, eh, el);
        exp_len = o[1] ? DIV_LAT : MUL_LAT;
        if (ce_at > 0 && ce_at < exp_len) exp_len += 5;
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b; mf_req = use_mf;
        exp_q.push_back({eh, el});
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (busy && cyc < 200) begin
            if (use_mf) check("stall_while_busy", 64'(stall), 64'd1);
            if (cyc == 20) begin
                check("hold_hi", 64'(hi), 64'(model_hi));
                check("hold_lo", 64'(lo), 64'(model_lo));
            end
            if (ce_at > 0 && cyc == ce_at)     clock_enable = 1'b0;
            if (ce_at > 0 && cyc == ce_at + 5) clock_enable = 1'b1;
            if (extra_start && cyc == 5) begin
                start = 1'b1; op = 2'($urandom_range(0, 3)); op_a = $urandom(); op_b = $urandom();
            end
            if (extra_start && cyc == 6) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        clock_enable = 1'b1;
        start = 1'b0;
        check("busy_length", 64'(cyc - 1), 64'(exp_len));
        check("done_after_busy", 64'(done), 64'd1);
        if (use_mf) check("stall_in_done", 64'(stall), 64'd0);
        mf_req = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        model_hi = eh;
        model_lo = el;
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        reset = 1'b1; clock_enable = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        mf_req = 1'b0; op = 2'b00; op_a = '0; op_b = '0; mt_data = '0;
        repeat (3) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 1'b0;
        model_hi = '0;
        model_lo = '0;

        // Directed arithmetic cases.
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0);
        run_op(2'b10, 32'd5, 32'd0, 1'b0, 0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        // Stall held from E0 and an ignored start during busy.
        run_op(2'b00, 32'd12345, 32'hFFFF_FD5A, 1'b1, 0, 1'b1);
        run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 0, 1'b1);
        // Clock enable low for 5 cycles mid-operation.
        run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 10, 1'b0);

        // MTHI aborts a MULTU in flight.
        @(negedge clk);
        start = 1'b1; op = 2'b01; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        repeat (ABORT_AT - 1) @(negedge clk);
        mthi = 1'b1; mt_data = 32'hA5A5_A5A5;
        @(negedge clk);
        mthi = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
        check("abort_lo", 64'(lo), 64'(model_lo));
        model_hi = 32'hA5A5_A5A5;
        expect_no_done("abort_no_done", 40);

        // Reset at E15 of a DIVU.
        @(negedge clk);
        start = 1'b1; op = 2'b11; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_hi", 64'(hi), 64'd0);
        check("midreset_lo", 64'(lo), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        model_hi = '0;
        model_lo = '0;
        expect_no_done("midreset_no_done", 40);

        // MTLO together with start: the move wins, start is dropped.
        @(negedge clk);
        start = 1'b1; op = 2'b10; op_a = 32'd9; op_b = 32'd2; mtlo = 1'b1; mt_data = 32'h0BAD_F00D;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        check("mt_start_busy", 64'(busy), 64'd0);
        check("mt_start_lo", 64'(lo), 64'h0000_0000_0BAD_F00D);
        check("mt_start_hi", 64'(hi), 64'(model_hi));
        model_lo = 32'h0BAD_F00D;
        expect_no_done("mt_start_no_done", 40);

        // Random operations interleaved with idle moves.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom();
                @(negedge clk);
                mthi = 1'($urandom_range(0, 1)); mtlo = 1'($urandom_range(0, 1)); mt_data = d;
                if (mthi) model_hi = d;
                if (mtlo) model_lo = d;
                @(negedge clk);
                mthi = 1'b0; mtlo = 1'b0;
                check("idle_mt_hi", 64'(hi), 64'(model_hi));
                check("idle_mt_lo", 64'(lo), 64'(model_lo));
            end
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 0,
                   1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_seq.md
# mips_muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair of the MIPS core. It accepts MULT/MULTU/DIV/DIVU requests from the decode stage and executes them over multiple cycles. It handles MTHI/MTLO writes and raises a stall to the core when MFHI/MFLO would read a result that is not yet complete.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- clock_enable  in  1  when low, all state, counters, HI and LO hold.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  funct[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- op_a  in  WIDTH  rs value (multiplicand/dividend), sampled with start.
- op_b  in  WIDTH  rt value (multiplier/divisor), sampled with start.
- mthi, mtlo  in  1  write mt_data to HI/LO.
- mt_data  in  WIDTH  MTHI/MTLO data.
- mf_req  in  1  decode stage is executing MFHI/MFLO.
- hi, lo  out  WIDTH  architectural HI/LO.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse after HI/LO are updated.
- stall  out  1  combinational: mf_req && busy.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE with start=1 (and clock_enable=1): latch |op_a| and |op_b| (two's-complement magnitude for signed ops, raw for unsigned), latch result sign and dividend sign, load counter = WIDTH-1, go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL: radix-2 shift-add, one partial product per cycle into a 2*WIDTH accumulator.
- DIV: radix-2 restoring division, one quotient bit per cycle.
- Counter decrements each iteration. Counter==0 transitions to FIX.
- FIX: apply signs. Product is negated if operand signs differ. Quotient is negated if signs differ. Remainder takes the dividend's sign. Write HI/LO (product: HI=upper, LO=lower; divide: HI=remainder, LO=quotient). Go to IDLE; done=1 in the following cycle.
- Divide by zero: the full latency applies; result HI=op_a, LO=all ones, with no sign fix.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- start while busy: ignored, not queued.
- mthi/mtlo in IDLE: write the register on the next edge. If asserted with start in the same cycle, the MT write wins and start is ignored.
- mthi/mtlo while busy: abort the operation (go to IDLE, no done), then perform the MT write. The other register holds its pre-operation value.
- mthi and mtlo in the same cycle: write both.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation abandons it with no done pulse.
- Edge E0 samples start. The state leaves IDLE after E0.
- Iterations occupy E1..E32. FIX is entered after E32.
- HI/LO are written at E33. done is high for the cycle after E33.
- busy = (state != IDLE), so busy is high for 33 cycles.
- hi/lo hold their old values until E33.
- stall deasserts in the same cycle that done asserts.
- clock_enable low stretches every interval; done remains held if clock_enable is low in its cycle.

## Configuration
- MULDIV_FAST_MUL_EN defined: MULT/MULTU compute the full product in one cycle. The MUL state lasts one cycle (E1 to FIX), HI/LO are written at E2, and busy is high for 2 cycles. DIV/DIVU are unchanged.
- MULDIV_FAST_MUL_EN undefined: the iterative multiplier described above, with 33-cycle busy.

## Structure
- Package mips_muldiv_pkg holds:
  - the op encoding enum (matches funct[1:0]);
  - the state enum;
  - the divide-by-zero LO constant (all ones).
- Sub-module muldiv_engine: the shift-add/restoring datapath (accumulator, partial remainder, iteration step).
- The top level keeps the FSM, counter, sign handling, HI/LO registers and the MT/MF logic.

## Test plan
- MULT op_a=-3, op_b=7: hi=0xFFFFFFFF, lo=0xFFFFFFEB at E33; done high one cycle; busy exactly 33 cycles.
- DIVU op_a=100, op_b=7: lo=14, hi=2. Then DIV op_a=-7, op_b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV op_a=5, op_b=0: hi=5, lo=0xFFFFFFFF after the full latency. DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mf_req held from E0: stall=1 through busy and 0 in the done cycle. start during busy: no effect on the result.
- MULTU started, mthi with mt_data=0xA5A5A5A5 at E10: busy drops, hi=0xA5A5A5A5, lo unchanged, no done pulse.
- reset at E15 of a DIVU: hi=lo=0, busy=0, no done. clock_enable low for 5 cycles mid-operation: done delayed exactly 5 cycles.
